// File: rtl/switch_input_ctrl.sv
// Switch/confirm-button input peripheral: synchronises and debounces the board inputs,
// snapshots the switches on each confirmed press and serves them on the CPU switch read bus.
module switch_input_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                switch_ctrl,
  input  logic [1:0]          sw_addr,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic                btn_confirm,
  output logic [15:0]         sw_rdata,
  output logic                confirm_pending
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btnState_e;

  logic [SW_WIDTH-1:0]  swMeta_q, swSync_q;
  logic [SW_WIDTH-1:0]  swStable_q, swStable_d;
  logic [CNT_WIDTH-1:0] swCnt_q, swCnt_d;
  logic                 swChanged;

  logic                 btnMeta_q, btnSync_q;
  btnState_e            btnState_q, btnState_d;
  logic [CNT_WIDTH-1:0] btCnt_q, btCnt_d;
  logic                 capture;

  logic [SW_WIDTH-1:0]  dataLatch_q, dataLatch_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 ack;

  // The counter restarts on the very edge the synced vector takes a new value.
  always_comb begin
    swChanged  = (swMeta_q != swSync_q);
    swCnt_d    = swCnt_q;
    swStable_d = swStable_q;
    if (swChanged) begin
      swCnt_d = '0;
    end else begin
      if (swCnt_q != DEB_MAX) swCnt_d = swCnt_q + CNT_ONE;
      if (swCnt_q == DEB_LAST) swStable_d = swSync_q;
    end
  end

  always_comb begin
    btnState_d = btnState_q;
    btCnt_d    = btCnt_q;
    capture    = 1'b0;
    case (btnState_q)
      IDLE: begin
        if (btnSync_q) begin
          btnState_d = PRESS_WAIT;
          btCnt_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btnSync_q) begin
          btnState_d = IDLE;
        end else if (btCnt_q == DEB_LAST) begin
          btnState_d = HELD;
          capture    = 1'b1;
        end else begin
          btCnt_d = btCnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btnSync_q) begin
          btnState_d = RELEASE_WAIT;
          btCnt_d    = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btnSync_q) begin
          btnState_d = HELD;
        end else if (btCnt_q == DEB_LAST) begin
          btnState_d = IDLE;
        end else begin
          btCnt_d = btCnt_q + CNT_ONE;
        end
      end
      default: btnState_d = IDLE;
    endcase
  end

  // A same-cycle ack consumed the old snapshot, so it never counts as an overrun.
  always_comb begin
    ack         = switch_ctrl && (sw_addr == 2'b00);
    dataLatch_d = dataLatch_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    if (capture) begin
      dataLatch_d = swStable_q;
      pending_d   = 1'b1;
      if (pending_q && !ack) overrun_d = 1'b1;
    end
    if (ack) begin
      overrun_d = 1'b0;
      if (!capture) pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta_q    <= '0;
      swSync_q    <= '0;
      swStable_q  <= '0;
      swCnt_q     <= '0;
      btnMeta_q   <= 1'b0;
      btnSync_q   <= 1'b0;
      btnState_q  <= IDLE;
      btCnt_q     <= '0;
      dataLatch_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      swMeta_q    <= sw_in;
      swSync_q    <= swMeta_q;
      swStable_q  <= swStable_d;
      swCnt_q     <= swCnt_d;
      btnMeta_q   <= btn_confirm;
      btnSync_q   <= btnMeta_q;
      btnState_q  <= btnState_d;
      btCnt_q     <= btCnt_d;
      dataLatch_q <= dataLatch_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  // Combinational so the IO stage sees data in the same cycle it selects us.
  always_comb begin
    sw_rdata = '0;
    if (switch_ctrl) begin
      case (sw_addr)
        2'b00:   sw_rdata = 16'(dataLatch_q);
        2'b01:   sw_rdata = 16'(swStable_q);
        2'b10:   sw_rdata = {14'b0, overrun_q, pending_q};
        default: sw_rdata = '0;
      endcase
    end
  end

  assign confirm_pending = pending_q;

endmodule
